// File: rtl/fd_reg_pkg.sv
// Shared F/D bundle layout and pipeline constants.
// Fetch fills pc/instr/exc; this stage owns bd; rsvd is always zero.
package fd_reg_pkg;

  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
  localparam logic [4:0]  EXC_NONE   = 5'd0;
  localparam logic [4:0]  EXC_ADEL   = 5'd4;

  typedef struct packed {
    logic [1:0]  rsvd;
    logic        bd;
    logic [4:0]  exc;
    logic [31:0] instr;
    logic [31:0] pc;
  } fd_msg_t;

  localparam int MSG_W = $bits(fd_msg_t);

  // Bit positions of each field inside the flat bundle.
  localparam int PC_LSB    = 0;
  localparam int INSTR_LSB = 32;
  localparam int EXC_LSB   = 64;
  localparam int BD_BIT    = 69;
  localparam int RSVD_LSB  = 70;

  function automatic fd_msg_t bubble(input logic [31:0] pc);
    fd_msg_t m;
    m    = '0;
    m.pc = pc;
    return m;
  endfunction

  function automatic fd_msg_t sanitise(input fd_msg_t f,
                                       input logic    bd);
    fd_msg_t m;
    m      = f;
    m.rsvd = '0;
    m.bd   = bd;
    if (f.exc != EXC_NONE)
      m.instr = '0;
    return m;
  endfunction

endpackage

// File: rtl/fd_reg.sv
// F/D pipeline register: latches the fetch bundle, tags valid/BD,
// and handles stall, flush and exception-request bubbles.
module fd_reg
  import fd_reg_pkg::*;
#(
  parameter logic [31:0] RESET_PC_P   = RESET_PC,
  parameter logic [31:0] HANDLER_PC_P = HANDLER_PC
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             flush,
  input  logic             req,
  input  logic             d_is_branch,
  input  logic [MSG_W-1:0] f_msg,
  output logic [MSG_W-1:0] msg,
  output logic             d_valid,
  output logic [31:0]      d_pc
);

  fd_msg_t msg_q, msg_d;
  logic    valid_q, valid_d;
  fd_msg_t f_in;

  assign f_in = fd_msg_t'(f_msg);

  always_comb begin
    msg_d   = msg_q;
    valid_d = valid_q;
    if (req) begin
      msg_d   = bubble(HANDLER_PC_P);
      valid_d = 1'b0;
    end else if (!en) begin
      msg_d   = msg_q;
      valid_d = valid_q;
    end else if (flush) begin
      // Keep the pc so a squashed slot never reports a zero macro-PC.
      msg_d   = bubble(f_in.pc);
      valid_d = 1'b0;
    end else begin
      msg_d   = sanitise(f_in, d_is_branch);
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      msg_q   <= bubble(RESET_PC_P);
      valid_q <= 1'b0;
    end else begin
      msg_q   <= msg_d;
      valid_q <= valid_d;
    end
  end

  assign msg     = msg_q;
  assign d_valid = valid_q;
  assign d_pc    = msg_q.pc;

endmodule
